mult_div_unit: RTL and testbench

Multicycle signed multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the multicycle MIPS datapath. The control unit launches `mult`/`div` with a one-cycle start pulse and stalls on `busy`. Operands come straight from the A/B operand registers. The unit iterates one bit per cycle and writes HI/LO on completion. HI/LO feed the write-back mux for `mfhi`/`mflo`, and `mthi`/`mtlo` write them directly.

---
 rtl/mult_div_pkg.sv | 19 +
 rtl/mult_div_if.sv | 26 ++
 rtl/md_negate.sv | 10 +
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = $clog2(MD_ITER);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FINISH
    } md_state_t;

    typedef enum logic {
        MD_MULT,
        MD_DIV
    } md_op_t;

endpackage

// File: rtl/mult_div_if.sv
// Control-unit side of the multiply/divide unit: launch, operands, HI/LO, status.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, op_a, op_b, hi_write, lo_write,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b, hi_write, lo_write,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/md_negate.sv
// Conditional two's-complement: y = neg ? -x : x.
module md_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);
    always_comb y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    mult_div_if.slave bus
);
    localparam int unsigned        W2       = 2 * WIDTH;
    localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITER - 1);

    md_state_t            state_q, state_d;
    md_op_t               op_q, op_d;
    logic [MD_CNT_W-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]        acc_q, acc_d;
    logic [WIDTH:0]       mag_q, mag_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     abs_a_c, abs_b_c;
    logic [W2-1:0]        prod_c;
    logic [WIDTH-1:0]     quot_c, rem_c;
    logic [WIDTH:0]       mult_sum_c;
    logic [W2-1:0]        mult_next_c;
    logic [WIDTH:0]       div_shift_c;
    logic                 div_ge_c;
    logic [WIDTH-1:0]     div_rem_c;
    logic [W2-1:0]        div_next_c;

    // Magnitudes at start; the most negative value maps onto its unsigned magnitude.
    md_negate #(.W(WIDTH)) u_abs_a (.x(bus.op_a), .neg(bus.op_a[WIDTH-1]), .y(abs_a_c));
    md_negate #(.W(WIDTH)) u_abs_b (.x(bus.op_b), .neg(bus.op_b[WIDTH-1]), .y(abs_b_c));

    // Sign application at FINISH; remainder follows the dividend sign.
    md_negate #(.W(W2))    u_prod  (.x(acc_q), .neg(neg_lo_q), .y(prod_c));
    md_negate #(.W(WIDTH)) u_quot  (.x(acc_q[WIDTH-1:0]), .neg(neg_lo_q), .y(quot_c));
    md_negate #(.W(WIDTH)) u_rem   (.x(acc_q[W2-1:WIDTH]), .neg(neg_hi_q), .y(rem_c));

    // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div.
    always_comb begin
        mult_sum_c  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? mag_q : '0);
        mult_next_c = {mult_sum_c, acc_q[WIDTH-1:1]};
        div_shift_c = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_ge_c    = (div_shift_c >= mag_q);
        div_rem_c   = div_ge_c ? WIDTH'(div_shift_c - mag_q) : div_shift_c[WIDTH-1:0];
        div_next_c  = {div_rem_c, acc_q[WIDTH-2:0], div_ge_c};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_mult)     state_d = ST_MULT;
                else if (bus.start_div) state_d = ST_DIV;
            end
            ST_MULT:   if (cnt_q == CNT_LAST)         state_d = ST_FINISH;
            ST_DIV:    if (dz_q || cnt_q == CNT_LAST) state_d = ST_FINISH;
            ST_FINISH: if (done_q)                    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_d      = mag_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        busy_d     = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (bus.start_mult || bus.start_div) begin
                    op_d     = bus.start_mult ? MD_MULT : MD_DIV;
                    cnt_d    = '0;
                    mag_d    = {1'b0, bus.start_mult ? abs_a_c : abs_b_c};
                    acc_d    = {WIDTH'(0), bus.start_mult ? abs_b_c : abs_a_c};
                    neg_lo_d = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                    neg_hi_d = bus.op_a[WIDTH-1];
                    dz_d     = !bus.start_mult && (bus.op_b == '0);
                end else begin
                    if (bus.hi_write) hi_d = bus.op_a;
                    if (bus.lo_write) lo_d = bus.op_a;
                end
            end
            ST_MULT: begin
                acc_d = mult_next_c;
                cnt_d = cnt_q + MD_CNT_W'(1);
            end
            ST_DIV: begin
                if (!dz_q) begin
                    acc_d = div_next_c;
                    cnt_d = cnt_q + MD_CNT_W'(1);
                end
            end
            ST_FINISH: begin
                // First FINISH cycle loads results; second one holds done high before IDLE.
                if (!done_q) begin
                    done_d = 1'b1;
                    if (op_q == MD_MULT) begin
                        {hi_d, lo_d} = prod_c;
                    end else if (dz_q) begin
                        div_zero_d = 1'b1;
                    end else begin
                        lo_d = quot_c;
                        hi_d = rem_c;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q       <= MD_MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_q      <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_q      <= mag_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random operations
// checked against a plain-arithmetic signed multiply/divide model.
module tb_mult_div_unit;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_if #(.WIDTH(32)) bus_if ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit product, C-style truncating divide/remainder.
    task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         output logic exp_dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        exp_dz = 1'b0;
        if (is_mult) begin
            p    = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 32'd0) begin
            exp_dz = 1'b1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end
    endtask

    task automatic mt_write(input bit to_hi, input logic [31:0] v);
        @(negedge clock);
        bus_if.op_a     = v;
        bus_if.hi_write = to_hi;
        bus_if.lo_write = !to_hi;
        @(posedge clock); #1;
        bus_if.hi_write = 1'b0;
        bus_if.lo_write = 1'b0;
        if (to_hi) begin
            m_hi = v;
            check("mthi", 64'(bus_if.hi), 64'(v));
        end else begin
            m_lo = v;
            check("mtlo", 64'(bus_if.lo), 64'(v));
        end
    endtask

    task automatic run_op(input string tag, input bit is_mult, input logic [31:0] a,
                          input logic [31:0] b, input bit both, input bit disturb);
        logic [31:0] prev_hi, prev_lo;
        logic        exp_dz;
        int          exp_lat;
        int          n;
        prev_hi = m_hi;
        prev_lo = m_lo;
        model(is_mult, a, b, exp_dz);
        exp_lat = exp_dz ? 2 : 33;

        @(negedge clock);
        bus_if.op_a       = a;
        bus_if.op_b       = b;
        bus_if.start_mult = is_mult;
        bus_if.start_div  = !is_mult || both;
        bus_if.hi_write   = both;
        bus_if.lo_write   = both;
        @(posedge clock); #1;
        bus_if.start_mult = 1'b0;
        bus_if.start_div  = 1'b0;
        bus_if.hi_write   = 1'b0;
        bus_if.lo_write   = 1'b0;
        bus_if.op_a       = $urandom;
        bus_if.op_b       = $urandom;
        check({tag, ":busy_e0"}, 64'(bus_if.busy), 64'd1);
        check({tag, ":hilo_e0"}, {bus_if.hi, bus_if.lo}, {prev_hi, prev_lo});

        n = 0;
        while (bus_if.done !== 1'b1 && n < 60) begin
            if (disturb && n == 5) begin
                bus_if.start_div = 1'b1;
                bus_if.hi_write  = 1'b1;
                bus_if.lo_write  = 1'b1;
                bus_if.op_a      = ~prev_hi;
            end
            if (n == 6) begin
                bus_if.start_div = 1'b0;
                bus_if.hi_write  = 1'b0;
                bus_if.lo_write  = 1'b0;
            end
            if (disturb && n == 7)
                check({tag, ":hi_busy_write"}, 64'(bus_if.hi), 64'(prev_hi));
            @(posedge clock); #1;
            n++;
        end
        check({tag, ":latency"}, 64'(n), 64'(exp_lat));
        check({tag, ":hi"}, 64'(bus_if.hi), 64'(m_hi));
        check({tag, ":lo"}, 64'(bus_if.lo), 64'(m_lo));
        check({tag, ":div_zero"}, 64'(bus_if.div_zero), 64'(exp_dz));
        check({tag, ":busy_done"}, 64'(bus_if.busy), 64'd1);
        @(posedge clock); #1;
        check({tag, ":idle"}, {62'd0, bus_if.busy, bus_if.done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rk, rd;

        reset             = 1'b0;
        bus_if.start_mult = 1'b0;
        bus_if.start_div  = 1'b0;
        bus_if.op_a       = '0;
        bus_if.op_b       = '0;
        bus_if.hi_write   = 1'b0;
        bus_if.lo_write   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_hi", 64'(bus_if.hi), 64'd0);
        check("rst_lo", 64'(bus_if.lo), 64'd0);
        check("rst_status", {61'd0, bus_if.busy, bus_if.done, bus_if.div_zero}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul_7x-3",    1'b1, 32'd7,        32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("mul_maxpos",  1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
        run_op("mul_minneg",  1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("div_-7/2",    1'b0, 32'hFFFF_FFF9, 32'd2,        1'b0, 1'b0);
        run_op("div_7/-2",    1'b0, 32'd7,        32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("div_min/-1",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

        mt_write(1'b1, 32'h11);
        mt_write(1'b0, 32'h22);
        run_op("div_by_0",    1'b0, 32'd5,        32'd0,         1'b0, 1'b0);

        run_op("busy_prot",   1'b1, 32'h0000_1234, 32'hFFFF_FFFB, 1'b0, 1'b1);
        run_op("both_start",  1'b1, 32'hFFFF_FFF7, 32'd11,       1'b1, 1'b0);
        run_op("div_prot",    1'b0, 32'h1234_5678, 32'hFFFF_FF00, 1'b0, 1'b1);

        // Abort a divide mid-iteration with an asynchronous reset.
        mt_write(1'b1, 32'h55);
        mt_write(1'b0, 32'h66);
        @(negedge clock);
        bus_if.op_a      = 32'hFFFF_FF9C;
        bus_if.op_b      = 32'd7;
        bus_if.start_div = 1'b1;
        @(posedge clock); #1;
        bus_if.start_div = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_status", {62'd0, bus_if.busy, bus_if.done}, 64'd0);
        check("midrst_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        run_op("post_rst_mul", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'(int'($urandom_range(1, 9)));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            rk = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), rk, ra, rb, 1'b0, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
